// File: rtl/wb_bridge_pkg.sv
// Shared types and constants for the management-to-project Wishbone timeout bridge.
package wb_bridge_pkg;

    localparam int unsigned WB_AW = 32;
    localparam int unsigned WB_DW = 32;
    localparam int unsigned WB_SW = 4;

    localparam logic [WB_AW-1:0] STATUS_OFS_CTRL  = 32'h0000_0000;
    localparam logic [WB_AW-1:0] STATUS_OFS_ADDR  = 32'h0000_0004;
    localparam logic [WB_DW-1:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Request payload as registered onto the project bus
    typedef struct packed {
        logic             we;
        logic [WB_SW-1:0] sel;
        logic [WB_AW-1:0] adr;
        logic [WB_DW-1:0] dat;
    } wb_req_t;

endpackage

// File: rtl/wb_timeout_timer.sv
// Cycle counter for the forwarding phase; expired_c flags the last cycle
// the bridge waits for a project ack before completing the cycle itself.
module wb_timeout_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired_c
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_c = (cnt_q == LAST);

    // Holds at LAST so an enable left high never wraps back to zero
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired_c) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_timeout_bridge.sv
// Registered Wishbone bridge from the management port to the shared project bus,
// self-completing with an error word when no project answers in time.
module wb_timeout_bridge
    import wb_bridge_pkg::*;
#(
    parameter int unsigned     TIMEOUT_CYCLES = 64,
    parameter logic [31:0]     STATUS_BASE    = 32'h3000_FF00,
    parameter logic [31:0]     ERR_DATA       = ERR_DATA_DEFAULT,
    parameter int unsigned     CNT_W          = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic        prj_cyc_o,
    output logic        prj_stb_o,
    output logic        prj_we_o,
    output logic [3:0]  prj_sel_o,
    output logic [31:0] prj_adr_o,
    output logic [31:0] prj_dat_o,
    input  logic        prj_ack_i,
    input  logic [31:0] prj_dat_i,
    output logic        timeout_irq_o
);

    state_t            state_q, state_d;
    wb_req_t           prj_q, prj_d;
    logic              prj_cyc_q, prj_cyc_d;
    logic              wbs_ack_q, wbs_ack_d;
    logic [31:0]       wbs_dat_q, wbs_dat_d;
    logic              irq_q, irq_d;
    logic [CNT_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [31:0]       last_adr_q, last_adr_d;
    logic              sticky_q, sticky_d;

    logic              req_c;
    logic              local_c;
    logic [31:0]       ofs_c;
    logic [31:0]       status_word_c;
    logic              tmr_clr_c;
    logic              tmr_en_c;
    logic              tmr_expired_c;

    // Addresses below STATUS_BASE underflow to a large offset and fall outside the window
    assign req_c         = wbs_cyc_i & wbs_stb_i;
    assign ofs_c         = wbs_adr_i - STATUS_BASE;
    assign local_c       = (ofs_c <= STATUS_OFS_ADDR);
    assign status_word_c = (ofs_c == STATUS_OFS_ADDR) ? last_adr_q
                                                      : {16'(tmo_cnt_q), 15'b0, sticky_q};

    assign tmr_en_c  = (state_q == FWD);
    assign tmr_clr_c = (state_q != FWD);

    wb_timeout_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (wb_clk_i),
        .rst       (wb_rst_i),
        .clr       (tmr_clr_c),
        .en        (tmr_en_c),
        .expired_c (tmr_expired_c)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Upstream abort takes priority over a project ack arriving in the same cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_c) begin
                    state_d = local_c ? ACK : FWD;
                end
            end
            FWD: begin
                if (!wbs_cyc_i) begin
                    state_d = IDLE;
                end else if (prj_ack_i || tmr_expired_c) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // An ack coinciding with expiry returns project data and leaves the counters alone
    always_comb begin
        prj_d      = prj_q;
        prj_cyc_d  = prj_cyc_q;
        wbs_ack_d  = 1'b0;
        wbs_dat_d  = wbs_dat_q;
        irq_d      = 1'b0;
        tmo_cnt_d  = tmo_cnt_q;
        last_adr_d = last_adr_q;
        sticky_d   = sticky_q;
        case (state_q)
            IDLE: begin
                if (req_c && local_c) begin
                    wbs_dat_d = status_word_c;
                    if (wbs_we_i && (ofs_c == STATUS_OFS_CTRL)) begin
                        tmo_cnt_d = '0;
                        sticky_d  = 1'b0;
                    end
                end else if (req_c) begin
                    prj_d     = '{we: wbs_we_i, sel: wbs_sel_i, adr: wbs_adr_i, dat: wbs_dat_i};
                    prj_cyc_d = 1'b1;
                end
            end
            FWD: begin
                if (!wbs_cyc_i) begin
                    prj_cyc_d = 1'b0;
                end else if (prj_ack_i) begin
                    prj_cyc_d = 1'b0;
                    wbs_dat_d = prj_dat_i;
                end else if (tmr_expired_c) begin
                    prj_cyc_d  = 1'b0;
                    wbs_dat_d  = ERR_DATA;
                    tmo_cnt_d  = (tmo_cnt_q == {CNT_W{1'b1}}) ? tmo_cnt_q
                                                              : tmo_cnt_q + CNT_W'(1);
                    last_adr_d = prj_q.adr;
                    sticky_d   = 1'b1;
                    irq_d      = 1'b1;
                end
            end
            ACK: begin
                wbs_ack_d = 1'b1;
            end
            default: begin
                prj_cyc_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            prj_q      <= '0;
            prj_cyc_q  <= 1'b0;
            wbs_ack_q  <= 1'b0;
            wbs_dat_q  <= '0;
            irq_q      <= 1'b0;
            tmo_cnt_q  <= '0;
            last_adr_q <= '0;
            sticky_q   <= 1'b0;
        end else begin
            prj_q      <= prj_d;
            prj_cyc_q  <= prj_cyc_d;
            wbs_ack_q  <= wbs_ack_d;
            wbs_dat_q  <= wbs_dat_d;
            irq_q      <= irq_d;
            tmo_cnt_q  <= tmo_cnt_d;
            last_adr_q <= last_adr_d;
            sticky_q   <= sticky_d;
        end
    end

    assign wbs_ack_o     = wbs_ack_q;
    assign wbs_dat_o     = wbs_dat_q;
    assign prj_cyc_o     = prj_cyc_q;
    assign prj_stb_o     = prj_cyc_q;
    assign prj_we_o      = prj_q.we;
    assign prj_sel_o     = prj_q.sel;
    assign prj_adr_o     = prj_q.adr;
    assign prj_dat_o     = prj_q.dat;
    assign timeout_irq_o = irq_q;

endmodule
